// File: rtl/uart_nios2_qsys_div_cell_if.sv
// ---------------------------------------------------------------------------
// uart_nios2_qsys_div_cell_if
//
// Purpose : Bundles the A-stage divide request/response signals between the
//           Nios II core pipeline (master) and the divide cell (slave).
//
// Signals :
//   A_div_start    master->slave  request, sampled only while the cell is idle
//   A_div_src1     master->slave  dividend, sampled with start
//   A_div_src2     master->slave  divisor, sampled with start
//   A_div_signed   master->slave  1 = signed operation, sampled with start
//   A_div_busy     slave->master  operation in flight (pipeline stalls on it)
//   A_div_done     slave->master  one-cycle pulse, results valid
//   A_div_quot     slave->master  quotient, held until the next done
//   A_div_rem      slave->master  remainder, held until the next done
//   A_div_by_zero  slave->master  divisor was zero, held with the results
// ---------------------------------------------------------------------------
interface uart_nios2_qsys_div_cell_if #(
    parameter int WIDTH = 32
);
    logic             A_div_start;
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_signed;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quot;
    logic [WIDTH-1:0] A_div_rem;
    logic             A_div_by_zero;

    modport master (
        output A_div_start, A_div_src1, A_div_src2, A_div_signed,
        input  A_div_busy, A_div_done, A_div_quot, A_div_rem, A_div_by_zero
    );

    modport slave (
        input  A_div_start, A_div_src1, A_div_src2, A_div_signed,
        output A_div_busy, A_div_done, A_div_quot, A_div_rem, A_div_by_zero
    );
endinterface

// File: rtl/uart_nios2_qsys_div_cell.sv
// ---------------------------------------------------------------------------
// uart_nios2_qsys_div_cell
//
// Purpose : Sequential radix-2 restoring divider for the Nios II A stage.
//           One result takes a fixed WIDTH+1 clocks after start is sampled:
//           WIDTH restoring steps followed by one fix-up cycle that applies
//           sign correction / divide-by-zero override and registers outputs.
//
// Ports   :
//   clk      in   core clock, all state updates on the rising edge
//   reset    in   synchronous reset, active-high (aborts any operation)
//   div_bus  slave modport of uart_nios2_qsys_div_cell_if (start/operands
//            in, busy/done/quot/rem/by_zero out)
//
// Parameters:
//   WIDTH    operand/result width, >= 2
//   CNT_W    iteration counter width, 2**CNT_W > WIDTH
//
// Configuration:
//   DIV_SIGNED_EN  when defined, A_div_signed=1 selects two's-complement
//                  division (quotient toward zero, remainder takes the
//                  dividend's sign). When undefined every operation is
//                  unsigned and no sign/negate logic is built.
// ---------------------------------------------------------------------------
module uart_nios2_qsys_div_cell #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    uart_nios2_qsys_div_cell_if.slave    div_bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_acc;
    logic [WIDTH-1:0] quot_acc;
    logic [WIDTH-1:0] divisor;

    logic             busy_q;
    logic             done_q;
    logic             by_zero_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             last_step;
    logic             divisor_zero;
    logic [WIDTH-1:0] load_dividend;
    logic [WIDTH-1:0] load_divisor;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;

    // The partial remainder never reaches 2**WIDTH, so its top bit only
    // exists to hold the shifted-in value during the trial subtraction.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_acc[WIDTH];

`ifdef DIV_SIGNED_EN
    logic             src1_neg;
    logic             src2_neg;
    logic             neg_quot;
    logic             neg_rem;
    logic [WIDTH-1:0] dividend_raw;

    assign src1_neg      = div_bus.A_div_signed & div_bus.A_div_src1[WIDTH-1];
    assign src2_neg      = div_bus.A_div_signed & div_bus.A_div_src2[WIDTH-1];
    assign load_dividend = src1_neg ? -div_bus.A_div_src1 : div_bus.A_div_src1;
    assign load_divisor  = src2_neg ? -div_bus.A_div_src2 : div_bus.A_div_src2;
`else
    logic unused_signed;
    assign unused_signed = div_bus.A_div_signed;
    assign load_dividend = div_bus.A_div_src1;
    assign load_divisor  = div_bus.A_div_src2;
`endif

    // Trial subtraction of one restoring step: shift the next dividend bit
    // (taken from the MSB of the quotient shift register) into the partial
    // remainder and subtract the divisor; a borrow means "restore".
    always_comb begin
        shifted      = {rem_acc[WIDTH-1:0], quot_acc[WIDTH-1]};
        {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};
        last_step    = (cnt == CNT_W'(WIDTH - 1));
        divisor_zero = (divisor == '0);
    end

    // Result fix-up for the FIX cycle. A zero divisor naturally produces
    // an all-ones quotient and leaves the dividend in the partial remainder,
    // but the override is written out so the signed build reports the
    // dividend exactly as presented rather than its magnitude.
    always_comb begin
        quot_final = quot_acc;
        rem_final  = rem_acc[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
        if (neg_quot) quot_final = -quot_acc;
        if (neg_rem)  rem_final  = -rem_acc[WIDTH-1:0];
        if (divisor_zero) begin
            quot_final = '1;
            rem_final  = dividend_raw;
        end
`else
        if (divisor_zero) begin
            quot_final = '1;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (div_bus.A_div_start) next_state = CALC;
            CALC:    if (last_step)           next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Datapath and registered outputs. busy is registered from the CALC
    // state so it is high exactly across the WIDTH iteration edges and has
    // already dropped when done pulses; the cycle in which done is high is
    // IDLE, so a start presented then is accepted immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            rem_acc   <= '0;
            quot_acc  <= '0;
            divisor   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            by_zero_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
`ifdef DIV_SIGNED_EN
            neg_quot     <= 1'b0;
            neg_rem      <= 1'b0;
            dividend_raw <= '0;
`endif
        end else begin
            busy_q <= (state == CALC);
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (div_bus.A_div_start) begin
                        quot_acc <= load_dividend;
                        divisor  <= load_divisor;
                        rem_acc  <= '0;
                        cnt      <= '0;
`ifdef DIV_SIGNED_EN
                        neg_quot     <= src1_neg ^ src2_neg;
                        neg_rem      <= src1_neg;
                        dividend_raw <= div_bus.A_div_src1;
`endif
                    end
                end
                CALC: begin
                    rem_acc  <= borrow ? shifted : diff;
                    quot_acc <= {quot_acc[WIDTH-2:0], ~borrow};
                    cnt      <= cnt + 1'b1;
                end
                FIX: begin
                    quot_q    <= quot_final;
                    rem_q     <= rem_final;
                    by_zero_q <= divisor_zero;
                end
                default: ;
            endcase
        end
    end

    assign div_bus.A_div_busy    = busy_q;
    assign div_bus.A_div_done    = done_q;
    assign div_bus.A_div_quot    = quot_q;
    assign div_bus.A_div_rem     = rem_q;
    assign div_bus.A_div_by_zero = by_zero_q;

endmodule
